// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
// Shares one single-ported, fixed-latency memory between the early_cpu
// instruction-fetch port and its load/store data port. One transaction is
// in flight at a time; data accesses win unless fetch has lost MAX_WAIT
// consecutive arbitrations while requesting.
module cpu_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  // Counter start value: the response arrives MEM_LAT cycles after the grant.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_WAIT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  lat_cnt_r;
  logic [3:0]  starve_cnt_r;
  logic        owner_d_r;     // 1: data port owns the transaction in flight

  logic        arb_s;         // this cycle may issue a new grant
  logic        done_s;        // the transaction in flight completes this cycle
  logic        fetch_win_s;
  logic        if_gnt_s;
  logic        d_gnt_s;

  // Arbitration: decide whether this is a grant cycle and who wins it.
  always_comb begin
    arb_s       = 1'b0;
    done_s      = 1'b0;
    fetch_win_s = 1'b0;
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    if (rst) begin
      arb_s  = 1'b0;
      done_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          arb_s = 1'b1;
        end
        BUSY: begin
          // The completion cycle doubles as the next arbitration cycle,
          // giving one transaction every MEM_LAT cycles under load.
          done_s = (lat_cnt_r == 4'd0);
          arb_s  = (lat_cnt_r == 4'd0);
        end
        default: begin
          arb_s  = 1'b0;
          done_s = 1'b0;
        end
      endcase
    end
    // Fetch only beats a competing data request once it has starved.
    fetch_win_s = if_req & (~d_req | (starve_cnt_r == MAX_CNT));
    if_gnt_s    = arb_s & if_req & fetch_win_s;
    d_gnt_s     = arb_s & d_req & ~fetch_win_s;
  end

  // Output steering: memory strobe carries the winner's fields, responses go to the owner.
  always_comb begin
    if_gnt    = if_gnt_s;
    d_gnt     = d_gnt_s;
    mem_en    = if_gnt_s | d_gnt_s;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_be    = {BE_W{1'b0}};
    if (d_gnt_s) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (if_gnt_s) begin
      mem_addr  = if_addr;
    end else begin
      mem_we    = 1'b0;
    end
    if_rvalid = done_s & ~owner_d_r;
    d_rvalid  = done_s & owner_d_r;
    if (if_rvalid) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = {DATA_W{1'b0}};
    end
    if (d_rvalid) begin
      d_rdata = mem_rdata;
    end else begin
      d_rdata = {DATA_W{1'b0}};
    end
  end

  // Transaction FSM, latency counter and fetch starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Dropping BUSY abandons any transaction in flight: no rvalid follows.
      state_r      <= IDLE;
      lat_cnt_r    <= 4'd0;
      starve_cnt_r <= 4'd0;
      owner_d_r    <= 1'b0;
    end else begin
      if (if_gnt_s | d_gnt_s) begin
        state_r   <= BUSY;
        lat_cnt_r <= LAT_LAST;
        owner_d_r <= d_gnt_s;
      end else if (state_r == BUSY) begin
        if (lat_cnt_r == 4'd0) begin
          state_r <= IDLE;
        end else begin
          lat_cnt_r <= lat_cnt_r - 4'd1;
        end
      end else begin
        state_r <= IDLE;
      end

      if (!if_req || if_gnt_s) begin
        starve_cnt_r <= 4'd0;
      end else if (d_gnt_s && (starve_cnt_r < MAX_CNT)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

endmodule
